fifo_sync_prog: RTL and testbench

Parametrised single-clock FIFO in plain RTL: configurable width and power-of-two depth, selectable standard or first-word-fall-through read mode, programmable full/empty thresholds, live occupancy count and sticky-free overflow/underflow pulses. It is the general successor to the fixed 32-deep vendor-macro FIFO and is used wherever engines need inter-stage buffering with back-pressure and known, tool-independent behaviour.

---
 rtl/fifo_sync_prog.sv | 106 ++++++++++
 tb/tb_fifo_sync_prog.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - parametrised single-clock FIFO with programmable thresholds and std/FWFT read modes
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int EMPTY_TH   = 3,
  parameter int FULL_TH    = 13,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  prog_empty,
  output logic                  prog_full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] EMPTY_TH_C = (ADDR_WIDTH+1)'(EMPTY_TH);
  localparam logic [ADDR_WIDTH:0] FULL_TH_C  = (ADDR_WIDTH+1)'(FULL_TH);

  // Refuse to build with thresholds or sizes that would make the flags meaningless
  generate
    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 ||
        EMPTY_TH < 0 || EMPTY_TH > DEPTH - 1 ||
        FULL_TH < 1 || FULL_TH > DEPTH || FULL_TH <= EMPTY_TH ||
        (FWFT != 0 && FWFT != 1)) begin : g_bad_params
      $fatal(1, "fifo_sync_prog: illegal parameter combination");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;

  // Every flag is a decode of the registered count, so no request reaches a flag combinationally
  assign empty      = (count_q == '0);
  assign full       = (count_q == DEPTH_C);
  assign prog_empty = (count_q <= EMPTY_TH_C);
  assign prog_full  = (count_q >= FULL_TH_C);
  assign data_count = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Next pointers and occupancy; a simultaneous accepted write and read leaves count alone
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
  end

  // Control state register; the reject pulses reflect the request seen at the previous edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
  end

  // Storage array is deliberately left unreset so it can map onto plain RAM
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown continuously; a pop simply advances the read pointer
      assign dout = mem[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      // Output register loads the head word only when a read is accepted
      always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr_q];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - scoreboard bench for fifo_sync_prog in std and FWFT modes
module tb_fifo_sync_prog;

  typedef struct {
    logic [5:0]  cnt;
    logic        e, f, pe, pf, ov, un, dchk;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        wr_s = 1'b0, rd_s = 1'b0, wr_f = 1'b0, rd_f = 1'b0;
  logic [31:0] din_s = '0, din_f = '0;
  logic [31:0] dout_s, dout_f;
  logic        empty_s, full_s, pe_s, pf_s, ov_s, un_s;
  logic        empty_f, full_f, pe_f, pf_f, ov_f, un_f;
  logic [5:0]  cnt_s;
  logic [4:0]  cnt_f;

  int checks = 0;
  int errors = 0;

  fifo_sync_prog u_std (
    .clk(clk), .rst(rst), .wr_en(wr_s), .din(din_s), .rd_en(rd_s), .dout(dout_s),
    .empty(empty_s), .full(full_s), .prog_empty(pe_s), .prog_full(pf_s),
    .overflow(ov_s), .underflow(un_s), .data_count(cnt_s)
  );

  fifo_sync_prog #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .EMPTY_TH(0), .FULL_TH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_f), .din(din_f), .rd_en(rd_f), .dout(dout_f),
    .empty(empty_f), .full(full_f), .prog_empty(pe_f), .prog_full(pf_f),
    .overflow(ov_f), .underflow(un_f), .data_count(cnt_f)
  );

  // Reference: a plain word queue per FIFO plus the last word handed out in std mode
  logic [31:0] mq_s[$];
  logic [31:0] mq_f[$];
  logic [31:0] std_dout = '0;
  exp_t        exp_s[$];
  exp_t        exp_f[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(input int m, input logic r, input logic w, input logic rd, input logic [31:0] d);
    int   depth, eth, fth, n;
    exp_t e;
    depth = (m == 0) ? 32 : 16;
    eth   = (m == 0) ? 3 : 0;
    fth   = (m == 0) ? 13 : 16;
    n     = (m == 0) ? mq_s.size() : mq_f.size();
    e.ov  = 1'b0;
    e.un  = 1'b0;
    if (r) begin
      if (m == 0) begin
        mq_s.delete();
        std_dout = '0;
      end else begin
        mq_f.delete();
      end
    end else begin
      e.ov = w && (n == depth);
      e.un = rd && (n == 0);
      if (rd && n > 0) begin
        if (m == 0) std_dout = mq_s.pop_front();
        else void'(mq_f.pop_front());
      end
      if (w && n < depth) begin
        if (m == 0) mq_s.push_back(d);
        else mq_f.push_back(d);
      end
    end
    n     = (m == 0) ? mq_s.size() : mq_f.size();
    e.cnt = 6'(n);
    e.e   = (n == 0);
    e.f   = (n == depth);
    e.pe  = (n <= eth);
    e.pf  = (n >= fth);
    if (m == 0) begin
      e.d    = std_dout;
      e.dchk = 1'b1;
      exp_s.push_back(e);
    end else begin
      e.dchk = (n > 0);
      e.d    = (n > 0) ? mq_f[0] : 32'h0;
      exp_f.push_back(e);
    end
  endtask

  task automatic step(input logic r, input logic ws, input logic rs, input logic [31:0] ds,
                      input logic wf, input logic rf, input logic [31:0] df);
    @(negedge clk);
    rst = r; wr_s = ws; rd_s = rs; din_s = ds; wr_f = wf; rd_f = rf; din_f = df;
    model(0, r, ws, rs, ds);
    model(1, r, wf, rf, df);
  endtask

  task automatic std_op(input logic r, input logic w, input logic rd, input logic [31:0] d);
    step(r, w, rd, d, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: one expectation per cycle per FIFO, compared just after the edge it describes
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_s.size() > 0) begin
        e = exp_s.pop_front();
        chk("std_count",      32'(cnt_s),   32'(e.cnt));
        chk("std_empty",      32'(empty_s), 32'(e.e));
        chk("std_full",       32'(full_s),  32'(e.f));
        chk("std_prog_empty", 32'(pe_s),    32'(e.pe));
        chk("std_prog_full",  32'(pf_s),    32'(e.pf));
        chk("std_overflow",   32'(ov_s),    32'(e.ov));
        chk("std_underflow",  32'(un_s),    32'(e.un));
        chk("std_dout",       dout_s,       e.d);
      end
      if (exp_f.size() > 0) begin
        e = exp_f.pop_front();
        chk("fwft_count",      32'(cnt_f),   32'(e.cnt));
        chk("fwft_empty",      32'(empty_f), 32'(e.e));
        chk("fwft_full",       32'(full_f),  32'(e.f));
        chk("fwft_prog_empty", 32'(pe_f),    32'(e.pe));
        chk("fwft_prog_full",  32'(pf_f),    32'(e.pf));
        chk("fwft_overflow",   32'(ov_f),    32'(e.ov));
        chk("fwft_underflow",  32'(un_f),    32'(e.un));
        if (e.dchk) chk("fwft_dout", dout_f, e.d);
      end
    end
  end

  initial begin : stimulus
    int pw, pr;
    // reset and idle
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) std_op(1'b0, 1'b0, 1'b0, 32'h0);
    // mid-stream reset at count 10
    for (int i = 0; i < 10; i++) std_op(1'b0, 1'b1, 1'b0, 32'h100 + i);
    std_op(1'b1, 1'b1, 1'b0, 32'hDEAD);
    std_op(1'b0, 1'b0, 1'b0, 32'h0);
    // fill 0x00..0x1F, one rejected write, then drain in order
    for (int i = 0; i < 32; i++) std_op(1'b0, 1'b1, 1'b0, 32'(i));
    std_op(1'b0, 1'b1, 1'b0, 32'h99);
    std_op(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 32; i++) std_op(1'b0, 1'b0, 1'b1, 32'h0);
    std_op(1'b0, 1'b0, 1'b0, 32'h0);
    // simultaneous write/read at full and at empty
    for (int i = 0; i < 32; i++) std_op(1'b0, 1'b1, 1'b0, 32'h200 + i);
    std_op(1'b0, 1'b1, 1'b1, 32'h2FF);
    for (int i = 0; i < 31; i++) std_op(1'b0, 1'b0, 1'b1, 32'h0);
    std_op(1'b0, 1'b1, 1'b1, 32'h3AA);
    std_op(1'b0, 1'b0, 1'b1, 32'h0);
    std_op(1'b0, 1'b0, 1'b0, 32'h0);
    // steady state at count 5 across several pointer wraps
    for (int i = 0; i < 5; i++) std_op(1'b0, 1'b1, 1'b0, 32'h400 + i);
    for (int i = 0; i < 60; i++) std_op(1'b0, 1'b1, 1'b1, 32'h500 + i);
    for (int i = 0; i < 5; i++) std_op(1'b0, 1'b0, 1'b1, 32'h0);
    // FWFT fall-through, pop, and read while empty
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA5);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 32'h0);
    // random traffic with drifting write/read bias and rare resets
    pw = 50; pr = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 400 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      step(($urandom_range(0, 1999) == 0),
           ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), $urandom(),
           ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), $urandom());
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #3;
    chk("std_pending", 32'(exp_s.size()), 32'h0);
    chk("fwft_pending", 32'(exp_f.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
